// File: rtl/countdown_timer60_if.sv
// Control/data bundle for the mm:ss countdown timer.
// With COUNTDOWN_BCD_EN defined the bundle also carries the BCD copies of both fields.
interface countdown_timer60_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       stop;
    logic [6:0] min_data;
    logic [6:0] sec_data;
    logic [6:0] min_out;
    logic [6:0] sec_out;
    logic       running;
    logic       borrow;
    logic       done;
    logic       alarm;
`ifdef COUNTDOWN_BCD_EN
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
`endif

    modport master (
        output tick, load, start, stop, min_data, sec_data,
        input  min_out, sec_out, running, borrow, done, alarm
`ifdef COUNTDOWN_BCD_EN
        , input min_bcd, sec_bcd
`endif
    );

    modport slave (
        input  tick, load, start, stop, min_data, sec_data,
        output min_out, sec_out, running, borrow, done, alarm
`ifdef COUNTDOWN_BCD_EN
        , output min_bcd, sec_bcd
`endif
    );
endinterface

// File: rtl/countdown_timer60.sv
// Minutes:seconds down-counter with preset, start/stop and a tick-timed alarm at 00:00.
// Define COUNTDOWN_BCD_EN to add registered BCD copies (min_bcd/sec_bcd) of both fields.
module countdown_timer60 #(
    parameter int unsigned ALARM_TICKS = 10,
    parameter int unsigned MAX_VAL     = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    countdown_timer60_if.slave   bus
);

    localparam int unsigned VAL_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam logic [VAL_W-1:0] MAX_V  = VAL_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] ALARM_V = CNT_W'(ALARM_TICKS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   min_q, min_d, sec_q, sec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
    logic               running_q, running_d;
    logic               alarm_q, alarm_d;

`ifdef COUNTDOWN_BCD_EN
    logic [7:0] min_bcd_q, sec_bcd_q;

    // Binary to {tens,units} by weighted compare/subtract; valid for 0..99.
    function automatic logic [7:0] to_bcd(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] r;
        logic [3:0]       tens;
        r    = v;
        tens = 4'd0;
        if (r >= VAL_W'(80)) begin r = r - VAL_W'(80); tens = tens + 4'd8; end
        if (r >= VAL_W'(40)) begin r = r - VAL_W'(40); tens = tens + 4'd4; end
        if (r >= VAL_W'(20)) begin r = r - VAL_W'(20); tens = tens + 4'd2; end
        if (r >= VAL_W'(10)) begin r = r - VAL_W'(10); tens = tens + 4'd1; end
        return {tens, r[3:0]};
    endfunction
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef COUNTDOWN_BCD_EN
            min_bcd_q <= 8'h00;
            sec_bcd_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            done_q    <= done_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
`ifdef COUNTDOWN_BCD_EN
            min_bcd_q <= to_bcd(min_d);
            sec_bcd_q <= to_bcd(sec_d);
`endif
        end
    end

    // Next state and values; load overrides everything, stop beats start and tick.
    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        sec_d    = sec_q;
        cnt_d    = cnt_q;
        borrow_d = 1'b0;
        done_d   = 1'b0;

        if (bus.load) begin
            min_d   = (bus.min_data > MAX_V) ? MAX_V : bus.min_data;
            sec_d   = (bus.sec_data > MAX_V) ? MAX_V : bus.sec_data;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop && ((min_q != '0) || (sec_q != '0)))
                        state_d = RUN;
                end
                PAUSE: begin
                    if (bus.start && !bus.stop)
                        state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (bus.tick) begin
                        if (sec_q != '0) begin
                            sec_d = sec_q - VAL_W'(1);
                            if ((sec_q == VAL_W'(1)) && (min_q == '0)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                cnt_d   = ALARM_V;
                            end
                        end else if (min_q != '0) begin
                            sec_d    = MAX_V;
                            min_d    = min_q - VAL_W'(1);
                            borrow_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (bus.tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
        alarm_d   = (state_d == DONE);
    end

    assign bus.min_out = min_q;
    assign bus.sec_out = sec_q;
    assign bus.running = running_q;
    assign bus.borrow  = borrow_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;
`ifdef COUNTDOWN_BCD_EN
    assign bus.min_bcd = min_bcd_q;
    assign bus.sec_bcd = sec_bcd_q;
`endif

endmodule
